// File: rtl/alu_pkg.sv
// Shared definitions for the iterative right-shift ALU: FSM state encoding
// and default datapath width.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } srx_state_e;

endpackage

// File: rtl/alu_sr_step.sv
// One-bit right step: drops the LSB and inserts the fill bit at the MSB.
module alu_sr_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_value
);

    // The bit shifted out is intentionally discarded.
    logic w_unused_lsb;

    assign w_unused_lsb = i_value[0];
    assign o_value      = {i_fill, i_value[WIDTH-1:1]};

endmodule

// File: rtl/alu_srx_iter.sv
// Iterative SRL/SRA unit: one bit per cycle, valid/ready request and
// response handshakes, result held in DONE until the consumer takes it.
module alu_srx_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [WIDTH-1:0] i_srx_data,
    input  logic [SHW-1:0]   i_srx_shift,
    input  logic             i_srx_arith,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_srx_result,
    output logic             o_busy
);

    srx_state_e       r_state;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_work;
    logic             r_fill;
    logic [WIDTH-1:0] w_step;

    alu_sr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_value (r_work),
        .i_fill  (r_fill),
        .o_value (w_step)
    );

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_fill  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_work <= i_srx_data;
                        r_cnt  <= i_srx_shift;
                        // Fill is fixed at acceptance: sign bit for SRA, zero for SRL.
                        r_fill <= i_srx_arith & i_srx_data[WIDTH-1];
                        if (i_srx_shift == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - SHW'(1);
                    if (r_cnt == SHW'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (i_rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = (r_state == IDLE);
    assign o_rsp_valid  = (r_state == DONE);
    assign o_busy       = (r_state != IDLE);
    assign o_srx_result = r_work;

endmodule

// File: tb/tb_alu_srx_iter.sv
// Self-checking bench for alu_srx_iter: directed corner cases plus a
// randomized run against an arithmetic reference model.
module tb_alu_srx_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] data;
    logic [4:0]  shift;
    logic        arith;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    alu_srx_iter #(.WIDTH(32), .SHW(5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_srx_data   (data),
        .i_srx_shift  (shift),
        .i_srx_arith  (arith),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_srx_result (result),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
        if (a) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request until accepted; n is the edge count of acceptance.
    task automatic accept(input logic [31:0] d, input logic [4:0] s, input logic a, output int n);
        int  guard;
        bit  acc;
        guard = 0;
        n = -1;
        req_valid = 1'b1; data = d; shift = s; arith = a;
        while (guard < 200) begin
            acc = (req_ready === 1'b1);
            step();
            guard++;
            if (acc) begin
                n = cyc;
                break;
            end
        end
        if (n < 0) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready stayed low, required 1");
        end
        req_valid = 1'b0;
        data  = $urandom;
        shift = 5'($urandom);
        arith = 1'($urandom);
    endtask

    // Waits for o_rsp_valid; lat is edges from acceptance to valid.
    task automatic wait_rsp(input int n, input bit bp, output int lat);
        int guard;
        guard = 0;
        lat = -1;
        while (guard < 100) begin
            if (rsp_valid === 1'b1) begin
                lat = cyc - n;
                break;
            end
            if (bp) rsp_ready = 1'($urandom_range(0, 1));
            step();
            guard++;
        end
        rsp_ready = 1'b0;
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout: rsp_valid stayed low, required 1");
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; data = 32'hCAFE_F00D; shift = 5'd5; arith = 1'b1;
        repeat (3) step();
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b busy=%b result=%h, required 0 0 00000000",
                     rsp_valid, busy, result);
        end
        rst_n = 1'b1;
        req_valid = 1'b0;
        step();
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [31:0] td [4];
        logic [4:0]  ts [4];
        logic        ta [4];
        logic [31:0] te [4];
        int n, lat;
        td[0] = 32'hF000_0000; ts[0] = 5'd4;  ta[0] = 1'b0; te[0] = 32'h0F00_0000;
        td[1] = 32'hF000_0000; ts[1] = 5'd4;  ta[1] = 1'b1; te[1] = 32'hFF00_0000;
        td[2] = 32'h8000_0000; ts[2] = 5'd31; ta[2] = 1'b1; te[2] = 32'hFFFF_FFFF;
        td[3] = 32'h1234_5678; ts[3] = 5'd0;  ta[3] = 1'b0; te[3] = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            accept(td[i], ts[i], ta[i], n);
            wait_rsp(n, 1'b0, lat);
            total++;
            if (lat !== int'(ts[i])) begin
                bad++;
                $display("FAIL dir%0d_latency: got %0d, required %0d", i, lat, ts[i]);
            end
            total++;
            if (result !== te[i]) begin
                bad++;
                $display("FAIL dir%0d_result: got %h, required %h", i, result, te[i]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int n, n2, lat, c0;
        exp = ref_shift(32'hA5A5_0F0F, 3, 1'b1);
        accept(32'hA5A5_0F0F, 5'd3, 1'b1, n);
        wait_rsp(n, 1'b0, lat);
        total++;
        if (lat != 3 || result !== exp) begin
            bad++;
            $display("FAIL bp_first: lat=%0d result=%h, required 3 %h", lat, result, exp);
        end
        req_valid = 1'b1; data = 32'h0000_F000; shift = 5'd2; arith = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (result !== exp || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: result=%h valid=%b ready=%b, required %h 1 0",
                         i, result, rsp_valid, req_ready, exp);
            end
        end
        handshake();
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_handshake_edge: valid=%b busy=%b ready=%b, required 0 0 1",
                     rsp_valid, busy, req_ready);
        end
        c0 = cyc;
        accept(32'h0000_F000, 5'd2, 1'b0, n2);
        total++;
        if (n2 != c0 + 1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_second_accept: edge=%0d busy=%b, required %0d 1", n2, busy, c0 + 1);
        end
        wait_rsp(n2, 1'b0, lat);
        total++;
        if (lat != 2 || result !== 32'h0000_3C00) begin
            bad++;
            $display("FAIL bp_second_result: lat=%0d result=%h, required 2 00003c00", lat, result);
        end
        handshake();
    endtask

    task automatic test_reset_midshift();
        int n;
        bit seen;
        accept(32'hDEAD_BEEF, 5'd10, 1'b1, n);
        step();
        rst_n = 1'b0;
        step();
        total++;
        if (rsp_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state: valid=%b result=%h busy=%b ready=%b, required 0 0 0 1",
                     rsp_valid, result, busy, req_ready);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            step();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL midreset_no_rsp: activity after reset seen=%b, required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, exp;
        logic [4:0]  s;
        logic        a;
        int n, lat, k;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 32'h0;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'h8000_0000;
                default: d = $urandom;
            endcase
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            exp = ref_shift(d, int'(s), a);
            rsp_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) step();
            accept(d, s, a, n);
            wait_rsp(n, 1'b1, lat);
            total++;
            if (lat != int'(s)) begin
                bad++;
                $display("FAIL rnd%0d_latency: got %0d, required %0d", i, lat, s);
            end
            total++;
            if (result !== exp) begin
                bad++;
                $display("FAIL rnd%0d_result: d=%h s=%0d a=%b got %h, required %h",
                         i, d, s, a, result, exp);
            end
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                step();
                total++;
                if (result !== exp || rsp_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd%0d_hold: result=%h valid=%b, required %h 1",
                             i, result, rsp_valid, exp);
                end
            end
            handshake();
            total++;
            if (rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rnd%0d_release: valid=%b, required 0", i, rsp_valid);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        data = '0; shift = '0; arith = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midshift();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
